// File: rtl/aes_pkg.sv
// aes_pkg
// Shared AES definitions used by the key schedule and the cipher datapath.
//   NR        : number of rounds for AES-128 (10)
//   block_t   : one 128-bit state/round-key block, byte 0 in bits [127:120]
//   kx_state_t: key-expansion control states (encoding doubles as 'busy')
//   SBOX      : forward S-box, SBOX[x] is the substitution of byte x
//   RCON      : round constants for rounds 1..10, RCON[0] belongs to round 1
//   rcon_of() : round constant for a round number, 0 outside 1..10
package aes_pkg;

   localparam int NR = 10;

   typedef logic [127:0] block_t;

   // IDLE/EXPAND encoded so that the state bit is the 'busy' flag itself.
   typedef enum logic {
      KX_IDLE   = 1'b0,
      KX_EXPAND = 1'b1
   } kx_state_t;

   // Row-major: element 0 is the leftmost byte of the first line.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [0:9][7:0] RCON = {
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
      logic [3:0] idx;
      idx     = rnd - 4'd1;
      rcon_of = 8'h00;
      if (rnd >= 4'd1 && rnd <= 4'd10) begin
         rcon_of = RCON[idx];
      end
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox
// Combinational AES forward S-box, one byte per instance.
//   a : input byte
//   s : substituted byte SBOX[a]
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] s
);

   assign s = SBOX[a];

endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand
// Iterative AES-128 key schedule. A start pulse loads the cipher key, then one
// round key is derived per clock into an (NR+1)-entry register file that the
// cipher reads through a combinational indexed port.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : load key and begin expansion (ignored while busy)
//   key       : 128-bit cipher key, word w0 = key[127:96]
//   busy      : expansion in progress
//   key_valid : all round keys stored and stable
//   rk_addr   : round-key index 0..NR; larger indices read as zero
//   rk_out    : round key rk[rk_addr], no read latency
module aes_key_expand #(
   parameter int NR = aes_pkg::NR    // only 10 (AES-128) is supported
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key,
   output logic         busy,
   output logic         key_valid,
   input  logic [3:0]   rk_addr,
   output logic [127:0] rk_out
);

   localparam logic [3:0] LAST_RND = 4'(NR);

   aes_pkg::kx_state_t state_q, state_d;

   logic [3:0]      rnd_q;
   aes_pkg::block_t w_q;
   aes_pkg::block_t rk_q [NR+1];

   logic load;    // accept a new key this edge
   logic step;    // derive and store one round key this edge
   logic last;    // this step writes the final round key

   // ------------------------------------------------------------------
   // Control
   // ------------------------------------------------------------------
   // NOTE: every register is written with <= so all flops sample the values
   // from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= aes_pkg::KX_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      last    = 1'b0;
      case (state_q)
         aes_pkg::KX_IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = aes_pkg::KX_EXPAND;
            end
         end
         aes_pkg::KX_EXPAND: begin
            // start is deliberately not looked at here: a running expansion
            // always completes with the key it was started with.
            step = 1'b1;
            if (rnd_q == LAST_RND) begin
               last    = 1'b1;
               state_d = aes_pkg::KX_IDLE;
            end
         end
         default: state_d = aes_pkg::KX_IDLE;
      endcase
   end

   assign busy = (state_q == aes_pkg::KX_EXPAND);

   // ------------------------------------------------------------------
   // Round function: one full round key (four words) per cycle
   // ------------------------------------------------------------------
   logic [31:0]     w3_rot;
   logic [31:0]     w3_sub;
   logic [31:0]     t;
   logic [31:0]     w0_n, w1_n, w2_n, w3_n;
   aes_pkg::block_t nxt;

   assign w3_rot = {w_q[23:0], w_q[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_subword
      aes_sbox u_sbox (
         .a (w3_rot[8*g +: 8]),
         .s (w3_sub[8*g +: 8])
      );
   end

   assign t    = w3_sub ^ {aes_pkg::rcon_of(rnd_q), 24'h0};
   assign w0_n = w_q[127:96] ^ t;
   assign w1_n = w_q[95:64]  ^ w0_n;
   assign w2_n = w_q[63:32]  ^ w1_n;
   assign w3_n = w_q[31:0]   ^ w2_n;
   assign nxt  = {w0_n, w1_n, w2_n, w3_n};

   // ------------------------------------------------------------------
   // Working register, round counter, key_valid
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q       <= '0;
         rnd_q     <= '0;
         key_valid <= 1'b0;
      end else if (load) begin
         w_q       <= key;
         rnd_q     <= 4'd1;
         key_valid <= 1'b0;
      end else if (step) begin
         w_q   <= nxt;
         rnd_q <= rnd_q + 4'd1;
         if (last) begin
            key_valid <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Round-key register file
   // ------------------------------------------------------------------
   // NOTE: this storage is flops, not a RAM macro, and it is reset on purpose:
   // after reset every address must read back as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= NR; i++) begin
            rk_q[i] <= '0;
         end
      end else if (load) begin
         rk_q[0] <= key;
      end else if (step) begin
         rk_q[rnd_q] <= nxt;
      end
   end

   // Combinational read; indices past the last round read as zero.
   always_comb begin
      rk_out = '0;
      if (rk_addr <= LAST_RND) begin
         rk_out = rk_q[rk_addr];
      end
   end

endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand
// Scoreboard bench for aes_key_expand. The stimulus process issues starts and
// pushes the expected schedule, computed by a word-wise FIPS-197 model with an
// S-box derived from GF(2^8) inversion, into a queue. A monitor pops an entry
// whenever key_valid rises and sweeps every read address against it.
`timescale 1ns/1ps
module tb_aes_key_expand;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key;
   logic         busy;
   logic         key_valid;
   logic [3:0]   rk_addr;
   logic [127:0] rk_out;

   always #5 clk = ~clk;

   aes_key_expand #(.NR(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .key       (key),
      .busy      (busy),
      .key_valid (key_valid),
      .rk_addr   (rk_addr),
      .rk_out    (rk_out)
   );

   typedef struct packed {
      logic [10:0][127:0] sched;
      logic               kat_en;
      logic [127:0]       kat1;
      logic [127:0]       kat10;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_RK1   = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   // ---------------- reference model ----------------
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xtime(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) b = {b[6:0], b[7]};
      return b;
   endfunction

   // Multiplicative inverse (x^254, 0 maps to 0) followed by the affine map.
   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon_ref(input int r);
      logic [7:0] c = 8'h01;
      for (int i = 1; i < r; i++) c = xtime(c);
      return c;
   endfunction

   function automatic logic [10:0][127:0] expand_ref(input logic [127:0] k);
      logic [31:0]        w [44];
      logic [31:0]        tmp;
      logic [10:0][127:0] s;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_ref(tmp[31:24]), sbox_ref(tmp[23:16]),
                   sbox_ref(tmp[15:8]),  sbox_ref(tmp[7:0])};
            tmp = tmp ^ {rcon_ref(i / 4), 24'h0};
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return s;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: owns rk_addr; zero sweep while in reset, scoreboard sweep on
   // each rising key_valid.
   initial begin : monitor
      logic         kv_prev;
      int           run;
      exp_t         e;
      logic [127:0] req;
      kv_prev = 1'b0;
      run     = 0;
      rk_addr = 4'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            run     = 0;
            kv_prev = 1'b0;
            check("rst_busy", busy, 0);
            check("rst_key_valid", key_valid, 0);
            for (int a = 0; a < 16; a++) begin
               rk_addr = 4'(a);
               #0.2;
               check($sformatf("rst_rk_out[%0d]", a), rk_out, 0);
            end
            rk_addr = 4'd0;
         end else begin
            if (busy) run++;
            if (key_valid && !kv_prev) begin
               check("busy_cycles", run, 10);
               check("busy_at_valid", busy, 0);
               run = 0;
               check("expect_pending", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  for (int a = 0; a < 16; a++) begin
                     rk_addr = 4'(a);
                     #0.2;
                     req = (a <= 10) ? e.sched[a] : 128'h0;
                     check($sformatf("rk_out[%0d]", a), rk_out, req);
                     if (e.kat_en && a == 1)  check("kat_rk1", rk_out, e.kat1);
                     if (e.kat_en && a == 10) check("kat_rk10", rk_out, e.kat10);
                  end
                  rk_addr = 4'd0;
               end
            end
            kv_prev = key_valid;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_start(input logic [127:0] k, input bit push, input bit kat,
                           input logic [127:0] k1, input logic [127:0] k10);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      key   = k;
      if (push) begin
         e.sched  = expand_ref(k);
         e.kat_en = kat;
         e.kat1   = k1;
         e.kat10  = k10;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Called 1ns after an edge; counts edges until key_valid is seen.
   task automatic wait_valid(input string name, input int lat);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!key_valid && n < 40);
      check({name, "_key_valid"}, key_valid, 1);
      check({name, "_latency"}, n, lat);
   endtask

   initial begin : stimulus
      logic [127:0] k;
      int           guard;
      rst   = 1'b1;
      start = 1'b0;
      key   = '0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("post_rst_busy", busy, 0);
      check("post_rst_key_valid", key_valid, 0);

      // FIPS-197 key
      do_start(FIPS_KEY, 1, 1, FIPS_RK1, FIPS_RK10);
      check("busy_after_start", busy, 1);
      check("key_valid_after_start", key_valid, 0);
      wait_valid("fips", 10);

      // all-zero key
      do_start(128'h0, 1, 1, ZERO_RK1, ZERO_RK10);
      wait_valid("zero", 10);

      // start re-pulsed at T+3 and T+7 with another key must be ignored
      do_start(FIPS_KEY, 1, 1, FIPS_RK1, FIPS_RK10);
      repeat (3) @(negedge clk);
      start = 1'b1;
      key   = 128'hdeadbeef_01234567_89abcdef_cafef00d;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("busy_during_ignore", busy, 1);
      wait_valid("ignore", 3);

      // reset at T+5, then a fresh expansion
      k = {$urandom, $urandom, $urandom, $urandom};
      do_start(k, 0, 0, 0, 0);
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_key_valid", key_valid, 0);
      check("midrst_rk_out", rk_out, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      k = {$urandom, $urandom, $urandom, $urandom};
      do_start(k, 1, 0, 0, 0);
      wait_valid("after_rst", 10);

      // back-to-back: second start at T+11 with the zero key
      k = {$urandom, $urandom, $urandom, $urandom};
      do_start(k, 1, 0, 0, 0);
      wait_valid("b2b_first", 10);
      do_start(128'h0, 1, 1, ZERO_RK1, ZERO_RK10);
      check("b2b_key_valid_fall", key_valid, 0);
      check("b2b_busy", busy, 1);
      wait_valid("b2b_second", 10);

      // random keys with random idle gaps
      for (int i = 0; i < 5; i++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         repeat ($urandom_range(0, 3)) @(posedge clk);
         do_start(k, 1, 0, 0, 0);
         wait_valid("rand", 10);
      end

      guard = 0;
      repeat (3) @(posedge clk);
      while (exp_q.size() != 0 && guard < 50) begin
         @(posedge clk);
         guard++;
      end
      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200us;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key schedule that sits directly upstream of `aes_cipher` and supplies its round keys. A 128-bit cipher key is loaded on a `start` pulse. One round key is then derived per clock and written into an 11-entry round-key register file. The cipher reads any round key through an indexed port once `key_valid` is asserted.

## Interface
Parameters:
- `NR`, 10: number of AES rounds. Fixed for AES-128, and only 10 is supported. Register file depth is `NR+1`.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: load `key` and begin expansion. Sampled only when `busy`=0.
- `key`, in, 128: cipher key. Byte 0 is `key[127:120]`, and word w0 is `key[127:96]`.
- `busy`, out, 1: expansion in progress.
- `key_valid`, out, 1: all 11 round keys are stored and stable.
- `rk_addr`, in, 4: round-key index, 0..10.
- `rk_out`, out, 128: round key `rk[rk_addr]`. Combinational read.

## Operation
- States are IDLE and EXPAND. The state is encoded by `busy` (IDLE = 0, EXPAND = 1).
- IDLE with `start`=1 at edge T:
  - `rk[0]` ← `key`.
  - Working register `w` ← `key`.
  - Round counter `rnd` ← 1.
  - `busy` ← 1.
  - `key_valid` ← 0.
- EXPAND, at each edge:
  - Compute `nxt` = f(`w`, `rcon[rnd]`).
  - `rk[rnd]` ← `nxt`.
  - `w` ← `nxt`.
  - `rnd` ← `rnd`+1.
  - If `rnd`=10: `busy` ← 0, `key_valid` ← 1, go to IDLE.
- Function f:
  - `t` = SubWord(RotWord(w3)) XOR {rcon, 24'h0}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - Result is {w0', w1', w2', w3'}.
- `rcon[1..10]` = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- `start` while `busy`=1 is ignored. The current expansion completes unaffected.
- `start` in IDLE with `key_valid`=1 restarts expansion:
  - `key_valid` drops at the next edge.
  - Old `rk[1..10]` contents are not guaranteed until `key_valid` reasserts.
- `rk_out` = `rk[rk_addr]` when `rk_addr` ≤ 10, and 128'h0 when `rk_addr` is 11..15.
- The read port is usable at any time. Contents are meaningful only while `key_valid`=1.
- Reset, including mid-expansion, asynchronously clears the following, and the block is in IDLE after release:
  - `busy` = 0, `key_valid` = 0, `rnd` = 0.
  - `w` = 0 and all `rk[*]` = 0, so `rk_out` = 0.

## Timing
- With `start` sampled at edge T:
  - `busy` = 1 from T through T+10.
  - `rk[i]` is written at edge T+i, for i = 0..10.
  - `busy` = 0 and `key_valid` = 1 after edge T+10.
- Start-to-`key_valid` latency is 10 cycles.
- A new `start` is accepted at edge T+11 at the earliest. Back-to-back throughput is 11 cycles per key.
- `rk_out` has zero cycles of latency from `rk_addr`. There is no register on the read path.
- Critical path per cycle: 4 S-box lookups, then the rcon XOR, then a 4-word XOR chain.

## Structure
- Shared package `aes_pkg` holds:
  - the S-box constant table (256×8);
  - the `rcon` table (10×8);
  - the typedef for a 128-bit block;
  - `NR`.
- `aes_pkg` is reused by `aes_cipher`.
- One sub-module `aes_sbox` (8-bit in, 8-bit out, combinational) is instantiated 4× for SubWord.
- The top level contains:
  - the 2-state control (`busy`, `rnd`, `key_valid`);
  - the working register `w`;
  - the 11×128 register file;
  - the read mux.

## Test plan
- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`, `start` pulse → `key_valid` 10 cycles later, with:
  - `rk[1]` = `a0fafe1788542cb123a339392a6c7605`;
  - `rk[10]` = `d014f9a8c9ee2589e13f0cc8b6630ca6`;
  - `rk[0]` = key.
- All-zero key → `rk[1]` = `62636363626363636263636362636363` and `rk[10]` = `b4ef5bcb3e92e21123e951cf6f8f188e`.
- `start` re-pulsed at T+3 and T+7 with a different key → ignored, and the results equal those for the first key.
- Assert `rst` at T+5 → immediately `busy` = 0, `key_valid` = 0, and `rk_out` = 0 for every address. A fresh `start` then expands correctly.
- `rk_addr` = 11 and 15 while `key_valid` = 1 → `rk_out` = 0. Sweep addresses 0..10 → contents match the reference model.
- Back-to-back: second `start` at T+11 with the zero key → `key_valid` falls at T+11 and rises at T+21 with the zero-key schedule.
